// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches over a ready handshake into the IR, and computes the next PC.
// Latency: one cycle in S_IDLE after reset; fetch completes on the imem_ready edge; consume-to-next-request is 1 cycle.
// Backpressure: imem_req is held with a stable address until imem_ready; the IR is held while instr_ready is low.
//
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   imem_req/addr/ready/rdata  instruction memory handshake (data returned in the accept cycle)
//   instr_valid/ready          IR handshake towards decode/control
//   instr, opcode              instruction register and its [31:26] field
//   Jump, Branch, Zero         control/ALU inputs, sampled only on the consume edge
//   pc, pc_plus4, instr_count  current PC, PC+4 and number of consumed instructions
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        Zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] cnt_q;
  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] next_pc;
  logic        load_ir;
  logic        consume;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath enables
  always_comb begin
    state_d = state_q;
    load_ir = 1'b0;
    consume = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_ready) begin
          load_ir = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          consume = 1'b1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next-PC selection; Jump has priority over a taken branch.
  assign pc4    = pc_q + 32'd4;
  assign br_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

  always_comb begin
    next_pc = pc4;
    if (Jump) begin
      next_pc = {pc4[31:28], ir_q[25:0], 2'b00};
    end else if (Branch && Zero) begin
      next_pc = pc4 + br_off;
    end
  end

  // PC, IR and consumed-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      ir_q  <= 32'd0;
      cnt_q <= 32'd0;
    end else begin
      if (load_ir) begin
        ir_q <= imem_rdata;
      end
      if (consume) begin
        pc_q  <= next_pc;
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  // Moore outputs: decoded from state and registers only.
  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == S_HOLD);
  assign instr       = ir_q;
  assign opcode      = ir_q[31:26];
  assign pc          = pc_q;
  assign pc_plus4    = pc4;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
module tb_mips_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        Jump, Branch, Zero;
  logic [31:0] pc, pc_plus4, instr_count;

  int checks = 0;
  int failures = 0;

  // Reference model: "have an instruction" flag plus architectural PC/IR/count.
  bit          m_started;
  bit          m_hold;
  logic [31:0] m_pc, m_ir, m_cnt;

  mips_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .opcode(opcode),
    .Jump(Jump), .Branch(Branch), .Zero(Zero),
    .pc(pc), .pc_plus4(pc_plus4), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_started = 1'b0;
    m_hold    = 1'b0;
    m_pc      = RST_PC;
    m_ir      = 32'd0;
    m_cnt     = 32'd0;
  endfunction

  function automatic logic [31:0] model_next(input logic j, input logic b, input logic z);
    logic [31:0] p4;
    int          off;
    p4  = m_pc + 32'd4;
    off = int'($signed(m_ir[15:0]));
    if (j) return {p4[31:28], m_ir[25:0], 2'b00};
    if (b && z) return p4 + 32'(off * 4);
    return p4;
  endfunction

  task automatic check_all(input string where);
    chk({where, ".imem_req"},    32'(imem_req),    32'(m_started && !m_hold));
    chk({where, ".imem_addr"},   imem_addr,        m_pc);
    chk({where, ".instr_valid"}, 32'(instr_valid), 32'(m_hold));
    chk({where, ".instr"},       instr,            m_ir);
    chk({where, ".opcode"},      32'(opcode),      32'(m_ir[31:26]));
    chk({where, ".pc"},          pc,               m_pc);
    chk({where, ".pc_plus4"},    pc_plus4,         m_pc + 32'd4);
    chk({where, ".instr_count"}, instr_count,      m_cnt);
  endtask

  // One clock: drive inputs at the falling edge, advance the model, check at the next falling edge.
  task automatic step(input logic mr, input logic [31:0] rd, input logic ir,
                      input logic j, input logic b, input logic z, input string where);
    imem_ready  = mr;
    imem_rdata  = rd;
    instr_ready = ir;
    Jump        = j;
    Branch      = b;
    Zero        = z;
    if (!m_started) begin
      m_started = 1'b1;
    end else if (!m_hold) begin
      if (mr) begin
        m_ir   = rd;
        m_hold = 1'b1;
      end
    end else if (ir) begin
      m_pc   = model_next(j, b, z);
      m_cnt  = m_cnt + 32'd1;
      m_hold = 1'b0;
    end
    @(negedge clk);
    check_all(where);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic fetch(input logic [31:0] rd, input int waits);
    for (int i = 0; i < waits; i++) step(1'b0, $urandom, rb(), rb(), rb(), rb(), "wait");
    step(1'b1, rd, rb(), rb(), rb(), rb(), "fetch");
  endtask

  task automatic consume(input logic j, input logic b, input logic z, input int stalls);
    for (int i = 0; i < stalls; i++) step(rb(), $urandom, 1'b0, rb(), rb(), rb(), "stall");
    step(rb(), $urandom, 1'b1, j, b, z, "consume");
  endtask

  initial begin
    logic [31:0] rd;
    rst_n = 1'b0; imem_ready = 1'b1; imem_rdata = 32'd0; instr_ready = 1'b0;
    Jump = 1'b0; Branch = 1'b0; Zero = 1'b0;
    model_reset();

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_all("reset");
    end
    chk("reset pc", pc, RST_PC);
    rst_n = 1'b1;

    // First edge leaves S_IDLE, request visible afterwards
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, "idle");
    chk("first req", 32'(imem_req), 32'd1);
    chk("first addr", imem_addr, 32'd0);

    // Sequential lw / sw
    fetch(32'h8C01_0004, 0);
    chk("lw opcode", 32'(opcode), 32'h23);
    consume(1'b0, 1'b0, 1'b0, 0);
    fetch(32'hAC01_0008, 0);
    chk("sw opcode", 32'(opcode), 32'h2B);
    chk("sw pc", pc, 32'h4);
    consume(1'b0, 1'b0, 1'b0, 0);
    chk("count after 2", instr_count, 32'd2);

    // Memory wait states
    fetch(32'h2001_0001, 3);
    consume(1'b0, 1'b0, 1'b0, 0);

    // Branch taken / not taken at pc 0x10
    fetch(32'h0800_0004, 0); consume(1'b1, 1'b0, 1'b0, 0);
    chk("jump to 0x10", pc, 32'h10);
    fetch(32'h1000_FFFC, 0); consume(1'b0, 1'b1, 1'b1, 0);
    chk("beq taken", pc, 32'h4);
    fetch(32'h0800_0004, 0); consume(1'b1, 1'b0, 1'b0, 0);
    fetch(32'h1000_FFFC, 0); consume(1'b0, 1'b1, 1'b0, 0);
    chk("beq not taken", pc, 32'h14);

    // Climb into region 0x2 via region-crossing jumps, then jump and priority
    fetch(32'h0BFF_FFFF, 0); consume(1'b1, 1'b0, 1'b0, 0);
    fetch(32'h0BFF_FFFF, 0); consume(1'b1, 1'b0, 1'b0, 0);
    fetch(32'h0000_0000, 0); consume(1'b0, 1'b0, 1'b0, 0);
    chk("pc at 0x20000000", pc, 32'h2000_0000);
    fetch(32'h0800_0040, 0); consume(1'b1, 1'b0, 1'b0, 0);
    chk("jump target", pc, 32'h2000_0100);
    fetch(32'h0800_0040, 0); consume(1'b1, 1'b1, 1'b1, 0);
    chk("jump beats branch", pc, 32'h2000_0100);

    // Walk up to 0xFFFFFFFC and wrap sequentially
    for (int i = 0; i < 20 && m_pc != 32'hFFFF_FFFC; i++) begin
      fetch(32'h0BFF_FFFF, 0); consume(1'b1, 1'b0, 1'b0, 0);
    end
    chk("pc at top", pc, 32'hFFFF_FFFC);
    fetch(32'h0000_0000, 0); consume(1'b0, 1'b0, 1'b0, 0);
    chk("pc wrap", pc, 32'h0);

    // Consumer stall in S_HOLD
    fetch(32'h8C01_0004, 1); consume(1'b0, 1'b0, 1'b0, 4);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      rd = $urandom;
      if ($urandom_range(0, 3) == 0) rd[31:26] = 6'h02;
      step(1'($urandom_range(0, 2) != 0), rd, rb(), rb(), rb(), rb(), "rand");
    end

    // Reset while in S_HOLD: IR lost, count unchanged
    for (int i = 0; i < 10 && !m_hold; i++) step(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, "to_hold");
    chk("in hold", 32'(instr_valid), 32'd1);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("rst_hold");
    @(negedge clk); rst_n = 1'b1;
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, "post_rst_hold");

    // Reset in the middle of S_REQ: request drops immediately
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, "req_wait");
    chk("req before rst", 32'(imem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("req drops async", 32'(imem_req), 32'd0);
    chk("pc async reset", pc, RST_PC);
    model_reset();
    check_all("rst_req");
    @(negedge clk); rst_n = 1'b1;
    step(1'b1, 32'h8C01_0004, 1'b0, 1'b0, 1'b0, 1'b0, "post_rst_req");
    fetch(32'h8C01_0004, 0);
    consume(1'b0, 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
